// File: rtl/vga_sync_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_receiver_if
// Desc     : 1-bit VGA stream (hsync, vsync, black/white pixel) between a
//            timing generator (master) and a sync receiver (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface vga_sync_receiver_if;
   logic hsync_in;
   logic vsync_in;
   logic pixel_in;

   modport master (
      output hsync_in,
      output vsync_in,
      output pixel_in
   );

   modport slave (
      input  hsync_in,
      input  vsync_in,
      input  pixel_in
   );
endinterface
`default_nettype wire

// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_receiver
// Desc     : Recovers pixel coordinates from a 1-bit VGA stream, checks line
//            and frame timing, reports lock, and captures a per-frame
//            lit-pixel count and one probe pixel.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_receiver #(
   parameter int H_ACTIVE        = 640,
   parameter int H_FRONT         = 24,
   parameter int H_SYNC          = 40,
   parameter int H_BACK          = 128,
   parameter int V_ACTIVE        = 480,
   parameter int V_FRONT         = 9,
   parameter int V_SYNC          = 3,
   parameter int V_BACK          = 28,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic                video_clk,
   input  logic                reset,
   vga_sync_receiver_if.slave  vga,
   input  logic [9:0]          probe_x,
   input  logic [9:0]          probe_y,
   output logic [9:0]          x_pos,
   output logic [9:0]          y_pos,
   output logic                active,
   output logic                locked,
   output logic                frame_done,
   output logic [18:0]         lit_count,
   output logic                probe_pixel,
   output logic                sync_err,
   output logic [7:0]          err_count
);

   localparam logic [9:0] c_h_total  = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
   localparam logic [9:0] c_h_last   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] c_v_last   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] c_h_vis_lo = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] c_h_vis_hi = 10'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [9:0] c_v_vis_lo = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] c_v_vis_hi = 10'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic       c_pol      = (SYNC_ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   // Normalised (1 = asserted) input samples and their registered copies
   logic        w_hs_n;
   logic        w_vs_n;
   logic        r_hs;
   logic        r_px;
   logic        r_vs_ls;      // vsync as sampled at the most recent line start
   logic        r_ls;         // line-start cycle (hs_r rose)
   logic        r_fs;         // frame-start cycle
   logic        w_ls_next;
   logic        w_fs_next;

   logic [9:0]  r_h_cnt;
   logic [9:0]  r_v_cnt;
   logic [9:0]  r_h_last;     // h_cnt value just before the latest line start
   logic [9:0]  r_v_last;     // v_cnt value just before the latest line start

   logic        w_line_bad;
   logic        w_timeout;
   logic        w_frame_bad;
   logic        w_viol;
   logic        w_capture;

   logic [18:0] r_acc;
   logic        r_probe;
   logic        r_frame_done;
   logic        r_sync_err;
   logic [18:0] r_lit_count;
   logic        r_probe_pixel;
   logic [7:0]  r_err_count;

   // The counters are loaded on the same edge that registers the sync edge,
   // so in the line-start cycle h_cnt already reads 0 and lines up with px_r.
   assign w_hs_n    = vga.hsync_in ^ c_pol;
   assign w_vs_n    = vga.vsync_in ^ c_pol;
   assign w_ls_next = w_hs_n & ~r_hs;
   assign w_fs_next = w_ls_next & w_vs_n & ~r_vs_ls;

   // Input stage: register syncs and pixel, flag line/frame start cycles
   always_ff @(posedge video_clk or posedge reset) begin
      if (reset) begin
         r_hs    <= 1'b0;
         r_px    <= 1'b0;
         r_vs_ls <= 1'b0;
         r_ls    <= 1'b0;
         r_fs    <= 1'b0;
      end else begin
         r_hs <= w_hs_n;
         r_px <= vga.pixel_in;
         r_ls <= w_ls_next;
         r_fs <= w_fs_next;
         if (w_ls_next) begin
            r_vs_ls <= w_vs_n;
         end
      end
   end

   // Horizontal/vertical position counters, saturating, with pre-reset snapshots
   always_ff @(posedge video_clk or posedge reset) begin
      if (reset) begin
         r_h_cnt  <= 10'd0;
         r_v_cnt  <= 10'd0;
         r_h_last <= 10'd0;
         r_v_last <= 10'd0;
      end else begin
         if (w_ls_next) begin
            r_h_last <= r_h_cnt;
            r_h_cnt  <= 10'd0;
            r_v_last <= r_v_cnt;
            if (w_fs_next) begin
               r_v_cnt <= 10'd0;
            end else if (r_v_cnt != 10'h3FF) begin
               r_v_cnt <= r_v_cnt + 10'd1;
            end
         end else if (r_h_cnt != 10'h3FF) begin
            r_h_cnt <= r_h_cnt + 10'd1;
         end
      end
   end

   // Timing checks; nothing is enforced while still searching for a frame
   assign w_line_bad  = r_ls & (r_h_last != c_h_last);
   assign w_timeout   = (r_h_cnt == c_h_total);
   assign w_frame_bad = r_fs & (r_v_last != c_v_last);
   assign w_viol      = (r_state != ST_SEARCH) & (w_line_bad | w_timeout | w_frame_bad);
   assign w_capture   = r_fs & (r_state == ST_LOCKED) & ~w_viol;

   // Lock FSM state register
   always_ff @(posedge video_clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_SEARCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Lock FSM next state: a violation always drops back to SEARCH
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_SEARCH: begin
            if (r_fs) begin
               w_state_next = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            if (w_viol) begin
               w_state_next = ST_SEARCH;
            end else if (r_fs) begin
               w_state_next = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (w_viol) begin
               w_state_next = ST_SEARCH;
            end
         end
         default: begin
            w_state_next = ST_SEARCH;
         end
      endcase
   end

   // Coordinates and visible-area qualifier
   always_comb begin
      x_pos  = r_h_cnt - c_h_vis_lo;
      y_pos  = r_v_cnt - c_v_vis_lo;
      locked = (r_state == ST_LOCKED);
      active = locked
               & (r_h_cnt >= c_h_vis_lo) & (r_h_cnt < c_h_vis_hi)
               & (r_v_cnt >= c_v_vis_lo) & (r_v_cnt < c_v_vis_hi);
   end

   // Per-frame capture: accumulate lit pixels and latch the probe pixel
   always_ff @(posedge video_clk or posedge reset) begin
      if (reset) begin
         r_acc   <= 19'd0;
         r_probe <= 1'b0;
      end else begin
         if (r_fs) begin
            r_acc <= 19'd0;
         end else if (active) begin
            r_acc <= r_acc + {18'd0, r_px};
         end
         if (active && (x_pos == probe_x) && (y_pos == probe_y)) begin
            r_probe <= r_px;
         end
      end
   end

   // Status outputs: error pulse/count and end-of-frame results
   always_ff @(posedge video_clk or posedge reset) begin
      if (reset) begin
         r_sync_err    <= 1'b0;
         r_err_count   <= 8'd0;
         r_frame_done  <= 1'b0;
         r_lit_count   <= 19'd0;
         r_probe_pixel <= 1'b0;
      end else begin
         r_sync_err   <= w_viol;
         r_frame_done <= w_capture;
         if (w_viol && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
         end
         if (w_capture) begin
            r_lit_count   <= r_acc;
            r_probe_pixel <= r_probe;
         end
      end
   end

   assign sync_err    = r_sync_err;
   assign err_count   = r_err_count;
   assign frame_done  = r_frame_done;
   assign lit_count   = r_lit_count;
   assign probe_pixel = r_probe_pixel;

endmodule
`default_nettype wire

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Sink-side counterpart to the clock's VGA timing generator. It consumes the 1-bit VGA stream (hsync, vsync, black/white pixel) on the 31.5 MHz `video_clk` domain and recovers the pixel coordinates. It checks line and frame timing against 640x480@72 parameters and reports a lock status. Per frame it captures the lit-pixel count and the value of one probe pixel. It is used as an on-chip loopback monitor and as the checker in the clock-face regression bench.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 24, front porch cycles
- `H_SYNC`, 40, hsync width
- `H_BACK`, 128, back porch cycles (H_TOTAL = sum = 832)
- `V_ACTIVE`, 480, visible lines
- `V_FRONT`, 9, front porch lines
- `V_SYNC`, 3, vsync width in lines
- `V_BACK`, 28, back porch lines (V_TOTAL = sum = 520)
- `SYNC_ACTIVE_LOW`, 1, sync polarity for both syncs (1 = asserted low)
- `video_clk  in  1  pixel clock, 31.5 MHz`
- `reset  in  1  asynchronous, active-high`
- `hsync_in  in  1  horizontal sync from generator`
- `vsync_in  in  1  vertical sync from generator`
- `pixel_in  in  1  black/white pixel`
- `probe_x  in  10  probe column, 0..639`
- `probe_y  in  10  probe row, 0..479`
- `x_pos  out  10  recovered column (valid when active)`
- `y_pos  out  10  recovered row (valid when active)`
- `active  out  1  locked and inside visible area`
- `locked  out  1  timing lock`
- `frame_done  out  1  one-cycle pulse, lit_count/probe_pixel updated`
- `lit_count  out  19  lit visible pixels in last locked frame`
- `probe_pixel  out  1  pixel value at (probe_x, probe_y), last locked frame`
- `sync_err  out  1  one-cycle pulse on any timing violation`
- `err_count  out  8  saturating violation count`

## Operation
- Input stage: `hsync_in`, `vsync_in` and `pixel_in` are registered once into hs_r, vs_r and px_r. Polarity is normalised so that 1 = asserted. Everything downstream uses the registered copies.
- Line start is the hsync assertion edge: hs_r=1 and the previous hs_r=0.
- h_cnt (10 bit):
  - Set to 0 on the line-start cycle.
  - Otherwise increments, saturating at 1023.
- vsync is sampled only at line starts. Frame start is a line start where vs_r=1 and vs_r was 0 at the previous line start.
- v_cnt (10 bit):
  - Set to 0 at frame start.
  - Otherwise increments at each line start, saturating at 1023.
- Line check: at a line start, the old h_cnt must equal H_TOTAL-1.
- Line timeout: h_cnt reaching H_TOTAL is a violation, flagged once per missing edge.
- Frame check: at frame start, the old v_cnt must equal V_TOTAL-1. This check is skipped in SEARCH.
- Any violation has these effects:
  - `sync_err` pulses for one cycle.
  - `err_count` increments, saturating at 255.
  - The FSM returns to SEARCH.
- FSM:
  - SEARCH: `locked`=0, violations ignored. Goes to MEASURE at frame start.
  - MEASURE: `locked`=0, violations enforced. Goes to LOCKED at the next frame start if no violation occurred.
  - LOCKED: `locked`=1. Goes to SEARCH on any violation.
- Coordinates:
  - x_pos = h_cnt - (H_SYNC+H_BACK).
  - y_pos = v_cnt - (V_SYNC+V_BACK).
  - Both are 10-bit modulo; values are meaningful only while `active`=1.
- `active` = `locked` and h_cnt in [168, 808) and v_cnt in [31, 511).
- Capture, only while `active`=1:
  - The accumulator adds px_r for each active pixel.
  - The probe latch takes px_r when x_pos==probe_x and y_pos==probe_y.
- Frame start in LOCKED:
  - The accumulator is copied to `lit_count`.
  - The probe latch is copied to `probe_pixel`.
  - `frame_done` pulses.
  - The accumulator clears.
- Frame start in SEARCH or MEASURE: the accumulator clears, and outputs are not updated.
- Simultaneous frame-start violation in LOCKED: the violation wins. There is no `frame_done`, `lit_count` is unchanged, and the FSM goes to SEARCH.
- `probe_x` and `probe_y` are sampled continuously. Changing them mid-frame gives an undefined probe result for that frame only.

## Timing
- Reset values:
  - FSM = SEARCH.
  - All counters, accumulators and registered inputs = 0, with the previous-sync registers set to deasserted.
  - Outputs: `locked`=0, `active`=0, `frame_done`=0, `sync_err`=0, `lit_count`=0, `probe_pixel`=0, `err_count`=0, `x_pos`/`y_pos` = reset-derived modulo values.
- Reset is asynchronous and can occur mid-frame. Lock is reacquired from scratch.
- Input-to-counter latency is 1 cycle: a pixel driven for generator column c appears with x_pos=c one cycle later.
- Lock timing:
  - `locked` rises on the cycle after the second valid frame start.
  - `locked` falls on the cycle after a violation.
- `sync_err`, `frame_done` and `lit_count`/`probe_pixel` all update on the cycle after the triggering line start.
- Nominal stream: `frame_done` period is 832*520 = 432,640 cycles.

## Test plan
- Nominal generator stream, all pixels 1:
  - `locked` rises after frame 2 start.
  - Every following `frame_done` gives `lit_count`=307200 and `err_count`=0.
- Pixel 1 only at (0,0) and (639,479):
  - With probe at (0,0), `probe_pixel`=1; with probe at (1,0), `probe_pixel`=0.
  - `lit_count`=2 in both cases.
- One line shortened to 831 cycles while locked: one `sync_err`, `locked`=0, `err_count`=1, relock two frame starts later.
- hsync held deasserted for 900 cycles: exactly one `sync_err`, when h_cnt reaches 832.
- Frame with 519 lines: violation at frame start, no `frame_done`, `lit_count` unchanged.
- `reset` asserted mid-frame while locked: all outputs return to reset values immediately, and lock is reacquired after two nominal frame starts.
